// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the socket, the error responder and the devices.
// Pure type/constant package: no logic, no latency.
// Flow control is valid/ready on both the A and D channels.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic {
        ERR_IDLE = 1'b0,
        ERR_RESP = 1'b1
    } err_state_e;

    // Read-back value returned for reads that target no device
    localparam logic [31:0] TL_ERR_DATA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    function automatic logic tl_a_is_read(tl_a_op_e op);
        return op == Get;
    endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// Error responder: answers any A request with a d_error response.
// Latency: response valid exactly one cycle after A acceptance.
// Backpressure: a_ready low while a response waits; holds response until d_ready.
module tlul_err_resp
    import tlul_pkg::*;
#(
    parameter logic [31:0] ErrRespData = TL_ERR_DATA
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o
);

    err_state_e state_q, state_d;
    tl_a_op_e   op_q, op_d;
    logic [1:0] size_q, size_d;
    logic [7:0] src_q, src_d;

    // Fields the responder never looks at
    logic unused_a_fields;
    assign unused_a_fields = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask, tl_h_i.a_data};

    // State and captured request registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ERR_IDLE;
            op_q    <= Get;
            size_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            src_q   <= src_d;
        end
    end

    // Next state: capture on accept, release on D handshake
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        src_d   = src_q;
        case (state_q)
            ERR_IDLE: begin
                if (tl_h_i.a_valid) begin
                    op_d    = tl_h_i.a_opcode;
                    size_d  = tl_h_i.a_size;
                    src_d   = tl_h_i.a_source;
                    state_d = ERR_RESP;
                end
            end
            ERR_RESP: begin
                if (tl_h_i.d_ready) begin
                    state_d = ERR_IDLE;
                end
            end
            default: state_d = ERR_IDLE;
        endcase
    end

    // Outputs depend on state only, never on a_valid
    always_comb begin
        tl_h_o          = '0;
        tl_h_o.d_opcode = AccessAck;
        if (state_q == ERR_IDLE) begin
            tl_h_o.a_ready = 1'b1;
        end else begin
            tl_h_o.d_valid  = 1'b1;
            tl_h_o.d_error  = 1'b1;
            tl_h_o.d_size   = size_q;
            tl_h_o.d_source = src_q;
            if (tl_a_is_read(op_q)) begin
                tl_h_o.d_opcode = AccessAckData;
                tl_h_o.d_data   = ErrRespData;
            end
        end
    end

endmodule

// File: rtl/tlul_socket_1n.sv
// 1-host to N-device TL-UL demux with in-order outstanding tracking and error responder.
// Latency: A path combinational (0 cycles); D path combinational from the latched target.
// Backpressure: stalls A while the count is full or the target changes with responses pending.
module tlul_socket_1n
    import tlul_pkg::*;
#(
    parameter int unsigned NumDev         = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] ErrRespData    = TL_ERR_DATA,
    localparam int unsigned SelW          = $clog2(NumDev + 1),
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    input  logic [SelW-1:0] dev_select_i,
    output tl_h2d_t         tl_d_o [NumDev],
    input  tl_d2h_t         tl_d_i [NumDev]
);

    localparam logic [SelW-1:0] ErrSel = SelW'(NumDev);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic [SelW-1:0] sel_q, sel_d, sel_in;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            hold, host_a_ready, host_d_valid, a_hs, d_hs;
    tl_h2d_t         err_h2d;
    tl_d2h_t         err_d2h, d_mux;

    tlul_err_resp #(.ErrRespData(ErrRespData)) u_err_resp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tl_h_i (err_h2d),
        .tl_h_o (err_d2h)
    );

    // Any out-of-range select folds onto the error responder
    always_comb sel_in = (dev_select_i >= ErrSel) ? ErrSel : dev_select_i;

    assign hold = (out_cnt_q == MaxCnt) | ((out_cnt_q != '0) & (sel_in != sel_q));

    // A steering: broadcast fields, qualify a_valid per target, route d_ready to latched target
    always_comb begin
        host_a_ready = 1'b0;
        for (int i = 0; i < NumDev; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid & ~hold & (sel_in == SelW'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready & (sel_q == SelW'(i));
            if (sel_in == SelW'(i)) begin
                host_a_ready = tl_d_i[i].a_ready;
            end
        end
        err_h2d         = tl_h_i;
        err_h2d.a_valid = tl_h_i.a_valid & ~hold & (sel_in == ErrSel);
        err_h2d.d_ready = tl_h_i.d_ready & (sel_q == ErrSel);
        if (sel_in == ErrSel) begin
            host_a_ready = err_d2h.a_ready;
        end
        host_a_ready = host_a_ready & ~hold;
    end

    // D return: only the latched target is listened to, and only with requests pending
    always_comb begin
        d_mux = err_d2h;
        for (int i = 0; i < NumDev; i++) begin
            if (sel_q == SelW'(i)) begin
                d_mux = tl_d_i[i];
            end
        end
        host_d_valid   = d_mux.d_valid & (out_cnt_q != '0);
        tl_h_o         = d_mux;
        tl_h_o.d_valid = host_d_valid;
        tl_h_o.a_ready = host_a_ready;
    end

    assign a_hs = tl_h_i.a_valid & host_a_ready;
    assign d_hs = host_d_valid & tl_h_i.d_ready;

    // Outstanding count and target latch
    always_comb begin
        sel_d     = sel_q;
        out_cnt_d = out_cnt_q;
        if (a_hs) begin
            sel_d = sel_in;
        end
        case ({a_hs, d_hs})
            2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Tracking registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            sel_q     <= sel_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) out_cnt_q <= MaxCnt);
    a_cnt_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(a_hs && !d_hs && out_cnt_q == MaxCnt));
    a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(d_hs && !a_hs && out_cnt_q == '0));

endmodule

// File: doc/tlul_socket_1n.md
Name: tlul_socket_1n

Overview:
- Parametrised 1-host to N-device TL-UL demultiplexing socket with outstanding-request tracking and a built-in error responder.
- Sits between a single TL-UL host (core or DMA port) and NumDev peripheral TL-UL devices, using the shared tlul_pkg channel structs.
- Steers each A request to the device chosen by a per-request select input, and returns D responses in order.
- Blocks device switches while responses are pending, so ordering is preserved without reorder buffers.

Parameters:
- NumDev, 4, number of downstream devices (1..16).
- MaxOutstanding, 4, maximum A requests accepted but not yet answered on D (>=1).
- ErrRespData, 32'hFFFF_FFFF, d_data returned by the error responder for Get.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- tl_h_i  input  tl_h2d_t  host request channel.
- tl_h_o  output  tl_d2h_t  host response channel.
- dev_select_i  input  $clog2(NumDev+1)  target for the current tl_h_i A beat; value NumDev selects the error responder; values >NumDev are also treated as error.
- tl_d_o  output  tl_h2d_t [NumDev]  per-device request channels.
- tl_d_i  input  tl_d2h_t [NumDev]  per-device response channels.

Behaviour:
- State:
  - out_cnt: $clog2(MaxOutstanding+1) bits.
  - sel_q: latched target.
  - Error responder FSM.
- Reset values:
  - out_cnt=0, sel_q=0, error FSM=IDLE.
  - All tl_d_o[i].a_valid=0 and tl_h_o.d_valid=0 while no requests are pending. Outputs derived from state are inactive after reset.
- Accept condition: hold = (out_cnt==MaxOutstanding) | (out_cnt!=0 & dev_select_i!=sel_q).
- A path (combinational, 0-cycle latency):
  - tl_d_o[s].a_valid = tl_h_i.a_valid & ~hold for s = dev_select_i; all other a_valid = 0.
  - All other A fields are broadcast unmodified to every device.
  - tl_h_o.a_ready = ~hold & (a_ready of selected device, or error responder ready).
- A handshake (host a_valid & a_ready):
  - sel_q <= dev_select_i.
  - out_cnt increments.
- D path:
  - tl_h_o D fields come from the source indexed by sel_q: device sel_q or the error responder.
  - d_ready is forwarded only to that source; every other device sees d_ready=0.
  - d_valid from non-selected devices is ignored; this is illegal by construction.
- D handshake (host d_valid & d_ready): out_cnt decrements.
- Simultaneous A and D handshake in one cycle: out_cnt unchanged, sel_q updated (equal to the old value by hold rule).
- out_cnt never exceeds MaxOutstanding and never underflows. Both are checked by SVA.
- sel_q is only meaningful when out_cnt!=0. A new target is accepted the same cycle out_cnt is 0, including the cycle the last D handshake completes only if out_cnt was already 0 at the start of the cycle (registered count, no combinational bypass).
- Error responder FSM:
  - States IDLE, RESP.
  - IDLE: a_ready=1. On accept, capture a_opcode, a_size, a_source and go to RESP.
  - RESP: a_ready=0, d_valid=1, d_error=1, d_sink=0, d_param=0, d_size/d_source echoed.
    - Get: d_opcode=AccessAckData, d_data=ErrRespData.
    - Put: d_opcode=AccessAck, d_data=0.
  - RESP goes to IDLE on d_ready.
  - Error response is valid exactly 1 cycle after A acceptance.
- Reset asserted mid-transaction: all state clears immediately; pending responses are dropped. Devices share the same reset.
- a_ready never combinationally depends on tl_h_i.a_valid (TL-UL rule). d_ready to devices never depends on device d_valid.

Decomposition:
- tlul_pkg: add a localparam TL_ERR_DATA default and a function tl_a_is_read(tl_a_op_e) for reuse.
- Sub-module tlul_err_resp: the IDLE/RESP responder with its own tl_h2d_t/tl_d2h_t ports.
- The socket instantiates one tlul_err_resp plus counter/steering logic.

Test Plan:
- Single Get to dev 2 (NumDev=4), dev replies AccessAckData 0x1234_5678 after 3 cycles -> tl_d_o[2].a_valid only; host sees d_data 0x1234_5678, d_source echoed; out_cnt 0->1->0.
- Four back-to-back Puts to dev 1, device withholds D -> first 4 accepted, 5th held (a_ready=0, no a_valid on any device) until first D handshake; out_cnt peaks at 4.
- Request to dev 0 pending, next request selects dev 3 -> stalled; dev 3 sees no a_valid until dev 0 D handshake completes and out_cnt returns to 0; then accepted.
- dev_select_i=4 (NumDev) Get, source 0x5A, size 2 -> next cycle host d_valid=1, d_error=1, AccessAckData, d_data 0xFFFF_FFFF, d_source 0x5A, d_size 2; no device sees a_valid.
- Same-cycle A handshake and D handshake at out_cnt=2, same device -> out_cnt stays 2.
- rst_i pulsed with out_cnt=3 and error FSM in RESP -> out_cnt=0, FSM IDLE, host d_valid=0 asynchronously; a fresh Get to dev 0 is accepted on the first cycle after release.
